// File: rtl/imm_pkg.sv
// Shared types and constants for the immediate generator: format codes,
// base-ISA opcodes and the output skid-buffer state encoding.
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_C    = 3'd6,
        FMT_NONE = 3'd7
    } imm_fmt_e;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/imm_gen_pipe_extract.sv
// Combinational immediate extraction (module imm_extract). Compressed
// instruction decoding is compiled in only when IMM_GEN_RVC_EN is defined.
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instruction,
    output logic [XLEN-1:0] imm,
    output imm_fmt_e        fmt,
    output logic            illegal,
    output logic            has_target
);

    localparam int SHAMT_W = (XLEN == 64) ? 6 : 5;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm32;
    logic        use_shamt;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];

    // imm32 is already sign-extended to 32 bits; widening to XLEN happens below.
    always_comb begin
        imm32      = '0;
        fmt        = FMT_NONE;
        illegal    = 1'b1;
        has_target = 1'b0;
        use_shamt  = 1'b0;
        if (instruction[1:0] == 2'b11) begin
            case (opcode)
                OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: begin
                    imm32     = {{20{instruction[31]}}, instruction[31:20]};
                    fmt       = FMT_I;
                    illegal   = 1'b0;
                    use_shamt = (opcode == OP_IMM) && ((funct3 == 3'b001) || (funct3 == 3'b101));
                end
                OP_IMM_32: begin
                    if (XLEN == 64) begin
                        imm32   = {{20{instruction[31]}}, instruction[31:20]};
                        fmt     = FMT_I;
                        illegal = 1'b0;
                    end
                end
                OP_STORE: begin
                    imm32   = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
                    fmt     = FMT_S;
                    illegal = 1'b0;
                end
                OP_BRANCH: begin
                    imm32      = {{19{instruction[31]}}, instruction[31], instruction[7],
                                  instruction[30:25], instruction[11:8], 1'b0};
                    fmt        = FMT_B;
                    illegal    = 1'b0;
                    has_target = 1'b1;
                end
                OP_LUI, OP_AUIPC: begin
                    imm32      = {instruction[31:12], 12'b0};
                    fmt        = FMT_U;
                    illegal    = 1'b0;
                    has_target = (opcode == OP_AUIPC);
                end
                OP_JAL: begin
                    imm32      = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                                  instruction[20], instruction[30:21], 1'b0};
                    fmt        = FMT_J;
                    illegal    = 1'b0;
                    has_target = 1'b1;
                end
                OP_REG: begin
                    fmt     = FMT_R;
                    illegal = 1'b0;
                end
                default: ;
            endcase
        end else begin
`ifdef IMM_GEN_RVC_EN
            // Quadrant and funct3 select the compressed form; C.ADDI16SP shares
            // the C.LUI encoding with rd=x2 and is left illegal.
            case ({instruction[1:0], instruction[15:13]})
                5'b01_000, 5'b01_010: begin
                    imm32   = {{26{instruction[12]}}, instruction[12], instruction[6:2]};
                    fmt     = FMT_C;
                    illegal = 1'b0;
                end
                5'b01_011: begin
                    if (instruction[11:7] != 5'd2) begin
                        imm32   = {{14{instruction[12]}}, instruction[12], instruction[6:2], 12'b0};
                        fmt     = FMT_C;
                        illegal = 1'b0;
                    end
                end
                5'b00_010, 5'b00_110: begin
                    imm32   = {25'b0, instruction[5], instruction[12:10], instruction[6], 2'b0};
                    fmt     = FMT_C;
                    illegal = 1'b0;
                end
                5'b01_101: begin
                    imm32      = {{20{instruction[12]}}, instruction[12], instruction[8],
                                  instruction[10:9], instruction[6], instruction[7],
                                  instruction[2], instruction[11], instruction[5:3], 1'b0};
                    fmt        = FMT_C;
                    illegal    = 1'b0;
                    has_target = 1'b1;
                end
                5'b01_110, 5'b01_111: begin
                    imm32      = {{23{instruction[12]}}, instruction[12], instruction[6:5],
                                  instruction[2], instruction[11:10], instruction[4:3], 1'b0};
                    fmt        = FMT_C;
                    illegal    = 1'b0;
                    has_target = 1'b1;
                end
                default: ;
            endcase
`endif
        end
    end

    assign imm = use_shamt ? XLEN'(instruction[20 +: SHAMT_W]) : XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with PC-relative target adder behind a 2-entry output
// skid buffer. Define IMM_GEN_RVC_EN to decode 16-bit compressed instructions.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] program_counter,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      imm_fmt,
    output logic [XLEN-1:0] target,
    output logic            illegal
);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        imm_fmt_e        fmt;
        logic            illegal;
    } entry_t;

    logic [XLEN-1:0] ext_imm;
    logic [XLEN-1:0] ext_target;
    imm_fmt_e        ext_fmt;
    logic            ext_illegal;
    logic            ext_has_target;

    entry_t                new_entry;
    entry_t                entry_reg  [SKID_DEPTH];
    entry_t                entry_next [SKID_DEPTH];
    skid_state_e           state_reg;
    skid_state_e           state_next;
    logic                  push;
    logic                  pop;
    logic [SKID_DEPTH-1:0] load_new;
    logic [SKID_DEPTH-1:0] load_shift;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .instruction (instruction),
        .imm         (ext_imm),
        .fmt         (ext_fmt),
        .illegal     (ext_illegal),
        .has_target  (ext_has_target)
    );

    // Wraps modulo 2^XLEN by construction of the adder width.
    assign ext_target = ext_has_target ? (program_counter + ext_imm) : '0;
    assign new_entry  = '{imm: ext_imm, target: ext_target, fmt: ext_fmt, illegal: ext_illegal};

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Entry 0 is always the head; entry 1 only fills when the head is stalled.
    always_comb begin
        state_next = state_reg;
        load_new   = '0;
        load_shift = '0;
        case (state_reg)
            SKID_EMPTY: begin
                if (push) begin
                    state_next  = SKID_ONE;
                    load_new[0] = 1'b1;
                end
            end
            SKID_ONE: begin
                if (push && pop) begin
                    load_new[0] = 1'b1;
                end else if (push) begin
                    state_next  = SKID_TWO;
                    load_new[1] = 1'b1;
                end else if (pop) begin
                    state_next = SKID_EMPTY;
                end
            end
            SKID_TWO: begin
                if (pop) begin
                    state_next    = SKID_ONE;
                    load_shift[0] = 1'b1;
                end
            end
            default: state_next = SKID_EMPTY;
        endcase
    end

    for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : g_entry
        assign entry_next[gi] = load_new[gi]   ? new_entry :
                                load_shift[gi] ? entry_reg[(gi + 1) % SKID_DEPTH] :
                                                 entry_reg[gi];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= SKID_EMPTY;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                entry_reg[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                entry_reg[i] <= entry_next[i];
            end
        end
    end

    // Handshake and data are forced low while rst is asserted, even before the first edge.
    assign in_ready  = ~rst & (state_reg != SKID_TWO);
    assign out_valid = ~rst & (state_reg != SKID_EMPTY);
    assign imm       = rst ? '0 : entry_reg[0].imm;
    assign target    = rst ? '0 : entry_reg[0].target;
    assign imm_fmt   = rst ? 3'd0 : entry_reg[0].fmt;
    assign illegal   = ~rst & entry_reg[0].illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: drives XLEN=32 and XLEN=64 instances with
// the same stimulus and checks both against an arithmetic reference model.
module tb_imm_gen_pipe;

    localparam logic [2:0] F_R = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3;
    localparam logic [2:0] F_U = 3'd4, F_J = 3'd5, F_C = 3'd6, F_NONE = 3'd7;
    localparam logic [6:0] OPS [12] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011,
                                        7'b0011011, 7'b0100011, 7'b1100011, 7'b0110111,
                                        7'b0010111, 7'b1101111, 7'b0110011, 7'b0001111};

    typedef struct {
        logic [31:0] inst;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [63:0] tgt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] instruction;
    logic [63:0] pc;

    logic        in_ready32, out_valid32, illegal32;
    logic [31:0] imm32, target32;
    logic [2:0]  fmt32;
    logic        in_ready64, out_valid64, illegal64;
    logic [63:0] imm64, target64;
    logic [2:0]  fmt64;

    exp_t q32[$];
    exp_t q64[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
        .instruction(instruction), .program_counter(pc[31:0]),
        .out_valid(out_valid32), .out_ready(out_ready), .imm(imm32),
        .imm_fmt(fmt32), .target(target32), .illegal(illegal32)
    );

    imm_gen_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
        .instruction(instruction), .program_counter(pc),
        .out_valid(out_valid64), .out_ready(out_ready), .imm(imm64),
        .imm_fmt(fmt64), .target(target64), .illegal(illegal64)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: immediates built as signed sums of weighted instruction fields.
    function automatic exp_t model(input int xlen, input logic [31:0] in, input logic [63:0] pc_v);
        exp_t        e;
        longint      v;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [2:0]  fmt;
        bit          tgt;
        op  = in[6:0];
        f3  = in[14:12];
        v   = 0;
        tgt = 0;
        fmt = F_NONE;
        if (in[1:0] == 2'b11) begin
            case (op)
                7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: begin
                    fmt = F_I;
                    v   = longint'($signed(in[31:20]));
                    if (op == 7'b0010011 && (f3 == 3'd1 || f3 == 3'd5))
                        v = (xlen == 64) ? longint'(in[25:20]) : longint'(in[24:20]);
                end
                7'b0011011: if (xlen == 64) begin
                    fmt = F_I;
                    v   = longint'($signed(in[31:20]));
                end
                7'b0100011: begin
                    fmt = F_S;
                    v   = 32 * longint'($signed(in[31:25])) + longint'(in[11:7]);
                end
                7'b1100011: begin
                    fmt = F_B; tgt = 1;
                    v   = -4096 * longint'(in[31]) + 2048 * longint'(in[7])
                          + 32 * longint'(in[30:25]) + 2 * longint'(in[11:8]);
                end
                7'b0110111, 7'b0010111: begin
                    fmt = F_U; tgt = (op == 7'b0010111);
                    v   = 4096 * longint'($signed(in[31:12]));
                end
                7'b1101111: begin
                    fmt = F_J; tgt = 1;
                    v   = -1048576 * longint'(in[31]) + 4096 * longint'(in[19:12])
                          + 2048 * longint'(in[20]) + 2 * longint'(in[30:21]);
                end
                7'b0110011: fmt = F_R;
                default: ;
            endcase
        end else begin
`ifdef IMM_GEN_RVC_EN
            case ({in[1:0], in[15:13]})
                5'b01000, 5'b01010: begin
                    fmt = F_C;
                    v   = -32 * longint'(in[12]) + longint'(in[6:2]);
                end
                5'b01011: if (in[11:7] != 5'd2) begin
                    fmt = F_C;
                    v   = 4096 * (-32 * longint'(in[12]) + longint'(in[6:2]));
                end
                5'b00010, 5'b00110: begin
                    fmt = F_C;
                    v   = 64 * longint'(in[5]) + 8 * longint'(in[12:10]) + 4 * longint'(in[6]);
                end
                5'b01101: begin
                    fmt = F_C; tgt = 1;
                    v   = -2048 * longint'(in[12]) + 1024 * longint'(in[8]) + 256 * longint'(in[10:9])
                          + 128 * longint'(in[6]) + 64 * longint'(in[7]) + 32 * longint'(in[2])
                          + 16 * longint'(in[11]) + 2 * longint'(in[5:3]);
                end
                5'b01110, 5'b01111: begin
                    fmt = F_C; tgt = 1;
                    v   = -256 * longint'(in[12]) + 64 * longint'(in[6:5]) + 32 * longint'(in[2])
                          + 8 * longint'(in[11:10]) + 2 * longint'(in[4:3]);
                end
                default: ;
            endcase
`endif
        end
        if (fmt == F_NONE) begin
            v   = 0;
            tgt = 0;
        end
        e.inst = in;
        e.fmt  = fmt;
        e.ill  = (fmt == F_NONE);
        e.imm  = v;
        e.tgt  = tgt ? (pc_v + e.imm) : 64'd0;
        if (xlen == 32) begin
            e.imm[63:32] = '0;
            e.tgt[63:32] = '0;
        end
        return e;
    endfunction

    task automatic compare_txn(input string tag, input exp_t e, input logic [63:0] act_imm,
                               input logic [63:0] act_tgt, input logic [2:0] act_fmt, input logic act_ill);
        check({tag, "_imm"}, act_imm, e.imm);
        check({tag, "_target"}, act_tgt, e.tgt);
        check({tag, "_fmt"}, 64'(act_fmt), 64'(e.fmt));
        check({tag, "_illegal"}, 64'(act_ill), 64'(e.ill));
        $display("txn %s inst=%h imm=%h target=%h fmt=%0d illegal=%0d",
                 tag, e.inst, act_imm, act_tgt, act_fmt, act_ill);
    endtask

    // Monitor: pops the scoreboard whenever a DUT hands over a result, and
    // checks that a stalled output does not move.
    initial begin
        exp_t        e;
        logic        held32, held64;
        logic [63:0] s_imm32, s_tgt32, s_imm64, s_tgt64;
        logic [3:0]  s_misc32, s_misc64;
        held32 = 0;
        held64 = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held32 = 0;
                held64 = 0;
            end else begin
                if (held32) begin
                    check("hold32_imm", 64'(imm32), s_imm32);
                    check("hold32_target", 64'(target32), s_tgt32);
                    check("hold32_ctrl", {60'd0, out_valid32, fmt32}, {60'd0, s_misc32});
                end
                if (held64) begin
                    check("hold64_imm", imm64, s_imm64);
                    check("hold64_target", target64, s_tgt64);
                    check("hold64_ctrl", {60'd0, out_valid64, fmt64}, {60'd0, s_misc64});
                end
                held32   = out_valid32 && !out_ready;
                held64   = out_valid64 && !out_ready;
                s_imm32  = 64'(imm32);
                s_tgt32  = 64'(target32);
                s_misc32 = {1'b1, fmt32};
                s_imm64  = imm64;
                s_tgt64  = target64;
                s_misc64 = {1'b1, fmt64};
                if (out_valid32 && out_ready) begin
                    if (q32.size() == 0) check("dut32_unexpected_output", 64'd1, 64'd0);
                    else begin
                        e = q32.pop_front();
                        compare_txn("dut32", e, 64'(imm32), 64'(target32), fmt32, illegal32);
                    end
                end
                if (out_valid64 && out_ready) begin
                    if (q64.size() == 0) check("dut64_unexpected_output", 64'd1, 64'd0);
                    else begin
                        e = q64.pop_front();
                        compare_txn("dut64", e, imm64, target64, fmt64, illegal64);
                    end
                end
            end
        end
    end

    // One cycle: drive at posedge+1, decide acceptance at the following negedge.
    task automatic step(input logic v, input logic [31:0] ins, input logic [63:0] p,
                        input logic ordy, output logic acc);
        in_valid    = v;
        instruction = ins;
        pc          = p;
        out_ready   = ordy;
        @(negedge clk);
        acc = v && in_ready32;
        if (v && in_ready32) q32.push_back(model(32, ins, p));
        if (v && in_ready64) q64.push_back(model(64, ins, p));
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] ins, input logic [63:0] p, input logic ordy);
        logic acc;
        int   n;
        n = 0;
        do begin
            step(1'b1, ins, p, ordy, acc);
            n++;
        end while (!acc && n < 20);
        check("offer_accepted", 64'(acc), 64'd1);
    endtask

    task automatic do_reset(input int cycles);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check("rst_in_ready", {62'd0, in_ready32, in_ready64}, 64'd0);
            check("rst_out_valid", {62'd0, out_valid32, out_valid64}, 64'd0);
            check("rst_data32", {imm32, target32} | 64'({fmt32, illegal32}), 64'd0);
            check("rst_data64", imm64 | target64 | 64'({fmt64, illegal64}), 64'd0);
            @(posedge clk);
            #1;
        end
        q32.delete();
        q64.delete();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {62'd0, in_ready32, in_ready64}, 64'd3);
        check("post_rst_out_valid", {62'd0, out_valid32, out_valid64}, 64'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        int          k;
        w = $urandom;
        k = $urandom_range(0, 15);
        if (k < 12) w[6:0] = OPS[k];
        else if (k < 15) w[1:0] = 2'($urandom_range(0, 2));
        return w;
    endfunction

    function automatic logic [63:0] rand_pc();
        logic [63:0] p;
        p = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) p[31:8] = '1;
        return p;
    endfunction

    initial begin
        logic acc;
        int   n;
        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        instruction = '0;
        pc          = '0;
        do_reset(3);

        offer(32'hFFF00093, 64'h0, 1'b1);
        offer(32'hFE000EE3, 64'h1000, 1'b1);
        offer(32'h0080006F, 64'hFFFFFFFC, 1'b1);
        offer(32'hFDB97531, 64'h2000, 1'b1);
        offer(32'h80000037, 64'h0, 1'b1);
        offer(32'h000050FD, 64'h40, 1'b1);
        offer(32'h01F09093, 64'h0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 64'h0, 1'b1, acc);

        step(1'b1, 32'h00100093, 64'h100, 1'b0, acc);
        check("bp_first_accepted", 64'(acc), 64'd1);
        step(1'b1, 32'h00200113, 64'h104, 1'b0, acc);
        check("bp_second_accepted", 64'(acc), 64'd1);
        step(1'b1, 32'h00300193, 64'h108, 1'b0, acc);
        check("bp_third_blocked", 64'(acc), 64'd0);
        offer(32'h00300193, 64'h108, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 64'h0, 1'b1, acc);

        step(1'b1, 32'h12345037, 64'h0, 1'b0, acc);
        step(1'b1, 32'h0000006F, 64'h0, 1'b0, acc);
        do_reset(2);

        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 9) < 7, rand_inst(), rand_pc(), $urandom_range(0, 9) < 6, acc);

        n = 0;
        while ((q32.size() != 0 || q64.size() != 0) && n < 50) begin
            step(1'b0, 32'h0, 64'h0, 1'b1, acc);
            n++;
        end
        check("drain_q32_empty", 64'(q32.size()), 64'd0);
        check("drain_q64_empty", 64'(q64.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
